// File: rtl/cacheline_burst_adapter.sv
// Cache-line to memory-burst adapter: serves 256-bit line reads and write-backs
// as four 64-bit beats on the memory bus, holding the assembled fill line for the cache.
module cacheline_burst_adapter #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    localparam int unsigned BEATS  = LINE_W / BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int unsigned CNT_W = $clog2(BEATS);

    typedef enum logic [2:0] {
        StIdle,
        StRdBurst,
        StRdDone,
        StWrBurst,
        StWrDone
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [LINE_W-1:0]  buffer_q;
    logic               last_beat;

    // The line is always 32-byte aligned, so the low address bits are never used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_i[4:0];

    assign last_beat = (count_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (write_i) begin
                    state_d = StWrBurst;
                end else if (read_i) begin
                    state_d = StRdBurst;
                end
            end
            StRdBurst: if (resp_i && last_beat) state_d = StRdDone;
            StRdDone:  state_d = StIdle;
            StWrBurst: if (resp_i && last_beat) state_d = StWrDone;
            StWrDone:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            buffer_q  <= '0;
            line_o    <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (write_i || read_i) begin
                        address_o <= {address_i[31:5], 5'b0};
                        count_q   <= '0;
                        if (write_i) begin
                            buffer_q <= line_i;
                            write_o  <= 1'b1;
                        end else begin
                            read_o <= 1'b1;
                        end
                    end
                end
                StRdBurst: begin
                    if (resp_i) begin
                        line_o[count_q*BURST_W +: BURST_W] <= burst_i;
                        count_q <= count_q + 1'b1;
                        if (last_beat) read_o <= 1'b0;
                    end
                end
                StWrBurst: begin
                    if (resp_i) begin
                        count_q <= count_q + 1'b1;
                        if (last_beat) write_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_o  = (state_q == StRdDone) || (state_q == StWrDone);
    assign burst_o = (state_q == StWrBurst) ? buffer_q[count_q*BURST_W +: BURST_W] : '0;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Scoreboard bench for cacheline_burst_adapter: stimulus pushes expected line
// transactions and write beats; a negedge monitor pops and compares them.
module tb_cacheline_burst_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           is_write;
        logic [31:0]  addr;
        logic [255:0] line;
    } txn_t;

    txn_t        txn_q[$];
    logic [63:0] beat_q[$];
    logic [255:0] last_line;

    cacheline_burst_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares write beats and completed transactions against the queues.
    initial begin
        logic prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_resp = 1'b0;
            end else begin
                if (read_o || write_o) chk("rd_wr_exclusive", 256'(read_o && write_o), 256'(0));
                if (write_o && resp_i) begin
                    if (beat_q.size() == 0) begin
                        chk("unexpected_wr_beat", 256'(1), 256'(0));
                    end else begin
                        chk("wr_beat", 256'(burst_o), 256'(beat_q.pop_front()));
                    end
                end
                if (resp_o) begin
                    chk("resp_single_cycle", 256'(prev_resp), 256'(0));
                    if (txn_q.size() == 0) begin
                        chk("unexpected_resp", 256'(1), 256'(0));
                    end else begin
                        txn_t t;
                        t = txn_q.pop_front();
                        chk("resp_address", 256'(address_o), 256'(t.addr));
                        if (!t.is_write) chk("resp_line", line_o, t.line);
                    end
                end
                prev_resp = resp_o;
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [255:0] l,
                           input logic [15:0] pat, input int n);
        int idx = 0;
        txn_q.push_back('{is_write: 1'b0, addr: {addr[31:5], 5'b0}, line: l});
        read_i    = 1'b1;
        address_i = addr;
        @(posedge clk); #1;
        chk("rd_req", 256'({read_o, write_o}), 256'(2'b10));
        for (int i = 0; i < n; i++) begin
            resp_i  = pat[i];
            burst_i = pat[i] ? l[idx*64 +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
            if (pat[i]) idx++;
            @(posedge clk); #1;
            if (idx < 4) chk("rd_hold", 256'(read_o), 256'(1));
        end
        resp_i = 1'b0;
        chk("rd_latency", 256'(resp_o), 256'(1));
        chk("rd_drop", 256'(read_o), 256'(0));
        read_i = 1'b0;
        @(posedge clk); #1;
        last_line = l;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] l,
                            input logic [15:0] pat, input int n, input logic also_read);
        txn_q.push_back('{is_write: 1'b1, addr: {addr[31:5], 5'b0}, line: l});
        for (int b = 0; b < 4; b++) beat_q.push_back(l[b*64 +: 64]);
        write_i   = 1'b1;
        read_i    = also_read;
        line_i    = l;
        address_i = addr;
        @(posedge clk); #1;
        chk("wr_req", 256'({read_o, write_o}), 256'(2'b01));
        line_i = '1;
        for (int i = 0; i < n; i++) begin
            resp_i = pat[i];
            @(posedge clk); #1;
        end
        resp_i = 1'b0;
        chk("wr_latency", 256'(resp_o), 256'(1));
        chk("wr_drop", 256'(write_o), 256'(0));
        chk("wr_done_burst_zero", 256'(burst_o), 256'(0));
        write_i = 1'b0;
        read_i  = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; line_i = '0; address_i = '0; read_i = 0; write_i = 0;
        burst_i = '0; resp_i = 0; last_line = '0;
        #3;
        chk("reset_outputs", {line_o}, 256'(0));
        chk("reset_ctrl", 256'({burst_o, address_o, read_o, write_o, resp_o}), 256'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_read(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                16'h000F, 4);
        chk("rd_addr_aligned", 256'(address_o), 256'(32'h0000_1220));

        // Spurious memory responses while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = 64'hFFFF_0000_FFFF_0000;
            @(posedge clk); #1;
            chk("spur_resp", 256'({resp_o, read_o, write_o}), 256'(0));
            chk("spur_line", line_o, last_line);
        end
        resp_i = 1'b0;

        do_read(32'h0000_2040, {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555},
                16'h0059, 7);

        do_write(32'h8000_00FF, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                 16'h000F, 4, 1'b0);
        chk("wr_addr_aligned", 256'(address_o), 256'(32'h8000_00E0));
        chk("line_hold_after_wr", line_o, last_line);

        // Both requests high: write goes first, read only after re-request.
        do_write(32'h1000_0047, {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                 64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101},
                 16'h002D, 6, 1'b1);
        chk("idle_after_dual", 256'({read_o, write_o, resp_o}), 256'(0));
        do_read(32'h1000_0047, {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                                64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A},
                16'h000F, 4);

        // Abort a read after two beats with an asynchronous reset between edges.
        read_i = 1'b1; address_i = 32'h0000_4000;
        @(posedge clk); #1;
        resp_i = 1'b1; burst_i = 64'h9999_9999_9999_9999;
        @(posedge clk); #1;
        burst_i = 64'h9A9A_9A9A_9A9A_9A9A;
        @(posedge clk); #1;
        resp_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("abort_line", line_o, 256'(0));
        chk("abort_ctrl", 256'({burst_o, address_o, read_o, write_o, resp_o}), 256'(0));
        read_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_resp", 256'(resp_o), 256'(0));

        do_read(32'h0000_4010, {64'hF4F4_F4F4_F4F4_F4F4, 64'hF3F3_F3F3_F3F3_F3F3,
                                64'hF2F2_F2F2_F2F2_F2F2, 64'hF1F1_F1F1_F1F1_F1F1},
                16'h000F, 4);
        chk("post_abort_addr", 256'(address_o), 256'(32'h0000_4000));

        repeat (3) @(posedge clk);
        #1;
        chk("txn_q_drained", 256'(txn_q.size()), 256'(0));
        chk("beat_q_drained", 256'(beat_q.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
